// File: rtl/data_mem_alt.sv
// data_mem_alt: one-write/one-read synchronous word store for the frame buffer.
// Active-low enables, registered read, write-first bypass, synchronous clear.
module data_mem_alt #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  logic do_wr;
  logic do_rd;
  logic bypass;

  assign do_wr  = ~wr_en;
  assign do_rd  = ~rd_en;
  assign bypass = do_wr && (rd_addr == wr_addr);

  // Next array contents: only the addressed word changes on a write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (do_wr) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Next read word: hold when disabled, forward write data on a same-address hit.
  always_comb begin
    rd_data_d = rd_data_q;
    if (do_rd) begin
      if (bypass) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem_q[rd_addr];
      end
    end
  end

  // State update; reset clears every word and the read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_data_mem_alt.sv
// tb_data_mem_alt: directed checks of data_mem_alt with DATA_WIDTH=16, ADDR_WIDTH=3.
// Inputs change after each rising edge; outputs sampled 1 time unit after it.
module tb_data_mem_alt;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;

  int compared   = 0;
  int mismatched = 0;

  data_mem_alt #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .wr_data(wr_data),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] exp);
    compared++;
    assert (rd_data === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, rd_data, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_en   = 1'b0;
    rd_addr = a;
    tick();
    rd_en   = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    tick();
    check("reset_state", 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b0;
      wr_addr = AW'(i);
      wr_data = 16'hFFFF;
      tick();
    end
    wr_en = 1'b1;
    rd(3'd2);
    check("pre_clear_read2", 16'hFFFF);

    reset = 1'b1;
    tick();
    check("clear_rd_data", 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(AW'(i));
      check($sformatf("clear_read%0d", i), 16'h0000);
    end

    for (int i = 1; i <= 4; i++) begin
      wr_en   = 1'b0;
      wr_addr = AW'(i);
      wr_data = DW'(i);
      tick();
    end
    wr_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rd(AW'(i));
      check($sformatf("wr_rd%0d", i), DW'(i));
    end

    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = 16'hDEAD;
    rd_en   = 1'b1;
    rd_addr = 3'd2;
    tick();
    wr_addr = 3'd3;
    wr_data = 16'hBEAD;
    rd_addr = 3'd0;
    tick();
    check("rd_hold", 16'h0004);
    rd(3'd1);
    check("wr_gate1", 16'h0001);
    rd(3'd3);
    check("wr_gate3", 16'h0003);

    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = 3'd5;
    rd_addr = 3'd5;
    wr_data = 16'hA5A5;
    tick();
    wr_en = 1'b1;
    rd_en = 1'b1;
    check("rdw_bypass", 16'hA5A5);
    rd(3'd5);
    check("rdw_stored", 16'hA5A5);

    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = 3'd6;
    wr_data = 16'h1234;
    rd_addr = 3'd1;
    tick();
    wr_en = 1'b1;
    rd_en = 1'b1;
    check("diff_addr_rd", 16'h0001);
    rd(3'd6);
    check("diff_addr_wr", 16'h1234);

    rd(3'd2);
    check("pre_mid_reset", 16'h0002);
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = 3'd7;
    rd_addr = 3'd7;
    wr_data = 16'hBEEF;
    tick();
    check("mid_reset_rd", 16'h0000);
    reset = 1'b0;
    wr_en = 1'b1;
    rd_en = 1'b1;
    rd(3'd6);
    check("mid_reset_read6", 16'h0000);
    rd(3'd7);
    check("mid_reset_read7", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
